// File: rtl/dbguart_rx.sv
// Debug UART receiver: 8N1 deserializer that packs REGLEN/8 bytes (first byte in bits [7:0]) into one strobed command word.
// Optional idle timeout that drops a partial word is built only when DBGUART_RX_TIMEOUT_EN is defined.
module dbguart_rx #(
    parameter int CLKFREQ      = 75_000_000,
    parameter int BAUDRATE     = 115_200,
    parameter int REGLEN       = 72,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    output logic [REGLEN-1:0] o_dbg,
    output logic              o_dbg_stb,
    output logic              o_frame_err,
    output logic              o_timeout
);

    localparam int CLKS_PER_BIT = CLKFREQ / BAUDRATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int NBYTES       = REGLEN / 8;
    localparam int TMR_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int CNT_W        = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    if (REGLEN == 0 || (REGLEN % 8) != 0 || TIMEOUT_BITS < 1 || HALF < 1) begin : g_param_check
        $error("dbguart_rx: invalid parameter set");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t             state, state_nxt;
    logic               rx_meta, rx_s;
    logic [TMR_W-1:0]   timer;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic [CNT_W-1:0]   byte_cnt;
    logic [REGLEN-1:0]  word, word_nxt;
    logic               tick, commit, frame_bad, shift_en, timeout_hit;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // START waits half a bit to land on the start-bit centre; later samples are a full bit apart.
    always_comb begin
        if (state == START) tick = (timer == TMR_W'(HALF - 1));
        else                tick = (timer == TMR_W'(CLKS_PER_BIT - 1));
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        frame_bad = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: if (tick) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        commit    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        word_nxt = word;
        word_nxt[8*int'(byte_cnt) +: 8] = shift;
    end

    // Bit timer and deserializer carry data only; the FSM restarts them on every frame.
    always_ff @(posedge i_clk) begin
        if (state == IDLE || state == BREAK || tick) timer <= '0;
        else                                         timer <= timer + 1'b1;
        if (state == START)  bit_idx <= '0;
        else if (shift_en)   bit_idx <= bit_idx + 1'b1;
        if (shift_en) shift <= {rx_s, shift[7:1]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_cnt    <= '0;
            o_dbg       <= '0;
            o_dbg_stb   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_dbg_stb   <= 1'b0;
            o_frame_err <= 1'b0;
            if (commit) begin
                word <= word_nxt;
                if (byte_cnt == CNT_W'(NBYTES - 1)) begin
                    o_dbg     <= word_nxt;
                    o_dbg_stb <= 1'b1;
                    byte_cnt  <= '0;
                end else begin
                    byte_cnt  <= byte_cnt + 1'b1;
                end
            end else if (frame_bad) begin
                o_frame_err <= 1'b1;
                byte_cnt    <= '0;
            end else if (timeout_hit) begin
                byte_cnt    <= '0;
            end
        end
    end

`ifdef DBGUART_RX_TIMEOUT_EN
    localparam int IDLE_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IDLE_W   = $clog2(IDLE_LIM + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Counts only while a partial word is waiting, so a host abort realigns the next word.
    assign timeout_hit = (state == IDLE) && (byte_cnt != '0) && (idle_cnt == IDLE_W'(IDLE_LIM - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || state != IDLE || byte_cnt == '0 || timeout_hit) idle_cnt <= '0;
        else                                                         idle_cnt <= idle_cnt + 1'b1;
        if (i_rst) o_timeout <= 1'b0;
        else       o_timeout <= timeout_hit;
    end
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_dbguart_rx.sv
// Bench for dbguart_rx: byte-level word model with a per-cycle event checker plus literal per-scenario expectations.
module tb_dbguart_rx;

    localparam int CLKFREQ      = 1_000_000;
    localparam int BAUDRATE     = 100_000;
    localparam int REGLEN       = 72;
    localparam int TIMEOUT_BITS = 20;
    localparam int CPB          = CLKFREQ / BAUDRATE;
    localparam int NB           = REGLEN / 8;
    localparam int K_STB        = 0;
    localparam int K_FERR       = 1;
    localparam int K_TMO        = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx  = 1'b1;
    logic [REGLEN-1:0] dbg;
    logic              stb, ferr, tmo;

    always #5 clk = ~clk;

    dbguart_rx #(
        .CLKFREQ(CLKFREQ), .BAUDRATE(BAUDRATE), .REGLEN(REGLEN), .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_rx(rx),
        .o_dbg(dbg), .o_dbg_stb(stb), .o_frame_err(ferr), .o_timeout(tmo)
    );

    typedef struct {
        int                kind;
        logic [REGLEN-1:0] val;
        int                lo;
        int                hi;
    } ev_t;

    ev_t               evq[$];
    int                stb_cyc[$];
    int                tests = 0;
    int                fails = 0;
    int                cyc = 0;
    int                n_stb = 0, n_ferr = 0, n_tmo = 0;
    int                mbytes = 0;
    logic [REGLEN-1:0] mword = '0;
    logic [REGLEN-1:0] exp_hold = '0;
    bit                skip = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [REGLEN-1:0] act, input logic [REGLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Every pulse must match the oldest outstanding expectation inside its window; o_dbg must hold the last word.
    always @(negedge clk) begin
        if (!skip) begin
            check("stb_ferr_exclusive", REGLEN'(stb & ferr), '0);
            for (int k = 0; k < 3; k++) begin
                logic p;
                p = (k == K_STB) ? stb : (k == K_FERR) ? ferr : tmo;
                if (p) begin
                    if (k == K_STB) begin n_stb++; stb_cyc.push_back(cyc); end
                    if (k == K_FERR) n_ferr++;
                    if (k == K_TMO) n_tmo++;
                    tests++;
                    if (evq.size() == 0 || evq[0].kind != k || cyc < evq[0].lo) begin
                        fails++;
                        $display("FAIL unexpected_pulse kind=%0d cyc=%0d: got 1, required 0", k, cyc);
                    end else begin
                        if (k == K_STB) begin
                            check("strobe_word", dbg, evq[0].val);
                            exp_hold = evq[0].val;
                        end
                        void'(evq.pop_front());
                    end
                end
            end
            check("dbg_hold", dbg, exp_hold);
            if (evq.size() > 0 && cyc > evq[0].hi) begin
                tests++;
                fails++;
                $display("FAIL missing_pulse kind=%0d deadline=%0d: got 0, required 1", evq[0].kind, evq[0].hi);
                void'(evq.pop_front());
            end
        end
    end

    task automatic push_ev(input int kind, input logic [REGLEN-1:0] val, input int lo, input int hi);
        ev_t e;
        e.kind = kind; e.val = val; e.lo = lo; e.hi = hi;
        evq.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            mword[8*mbytes +: 8] = b;
            if (mbytes == NB - 1) begin
                push_ev(K_STB, mword, cyc, cyc + 2*CPB);
                mbytes = 0;
            end else begin
                mbytes++;
            end
        end else begin
            push_ev(K_FERR, '0, cyc, cyc + 2*CPB);
            mbytes = 0;
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick_n(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        model_byte(b, stop_ok);
        drive_bit(stop_ok);
    endtask

    task automatic send_word(input logic [7:0] first);
        for (int i = 0; i < NB; i++) send_byte(first + 8'(i), 1'b1);
    endtask

    task automatic idle_bits(input int n);
`ifdef DBGUART_RX_TIMEOUT_EN
        if (mbytes != 0 && n >= TIMEOUT_BITS + 3) begin
            push_ev(K_TMO, '0, cyc + (TIMEOUT_BITS - 2)*CPB, cyc + (TIMEOUT_BITS + 2)*CPB);
            mbytes = 0;
        end
`endif
        rx = 1'b1;
        tick_n(n * CPB);
    endtask

    task automatic do_reset(input string tag, input int n);
        skip = 1'b1;
        rx   = 1'b1;
        rst  = 1'b1;
        tick_n(n);
        rst  = 1'b0;
        evq.delete();
        mbytes   = 0;
        exp_hold = '0;
        check({tag, "_dbg"},   dbg, '0);
        check({tag, "_stb"},   REGLEN'(stb), '0);
        check({tag, "_ferr"},  REGLEN'(ferr), '0);
        check({tag, "_tmo"},   REGLEN'(tmo), '0);
        skip = 1'b0;
    endtask

    int bs, bf, bt;

    task automatic mark();
        bs = n_stb; bf = n_ferr; bt = n_tmo;
    endtask

    initial begin
        do_reset("reset", 3);
        idle_bits(2);

        mark();
        send_word(8'h01);
        idle_bits(2);
        check("w1_strobes", REGLEN'(n_stb - bs), REGLEN'(1));
        check("w1_ferrs",   REGLEN'(n_ferr - bf), '0);
        check("w1_word",    dbg, 72'h090807060504030201);

        mark();
        rx = 1'b0;
        tick_n(3);
        idle_bits(3);
        check("glitch_strobes", REGLEN'(n_stb - bs), '0);
        check("glitch_ferrs",   REGLEN'(n_ferr - bf), '0);
        send_word(8'h31);
        idle_bits(2);
        check("post_glitch_word", dbg, 72'h393837363534333231);

        mark();
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1'b1);
        send_byte(8'hA5, 1'b0);
        idle_bits(1);
        send_word(8'h11);
        idle_bits(2);
        check("ferr_count",   REGLEN'(n_ferr - bf), REGLEN'(1));
        check("ferr_strobes", REGLEN'(n_stb - bs), REGLEN'(1));
        check("ferr_word",    dbg, 72'h191817161514131211);

        mark();
        send_word(8'h41);
        send_word(8'h51);
        idle_bits(2);
        check("b2b_strobes", REGLEN'(n_stb - bs), REGLEN'(2));
        if (stb_cyc.size() >= 2)
            check("b2b_spacing", REGLEN'(stb_cyc[stb_cyc.size()-1] - stb_cyc[stb_cyc.size()-2]), REGLEN'(900));
        check("b2b_word", dbg, 72'h595857565554535251);

        mark();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        idle_bits(25);
        send_word(8'h21);
        idle_bits(2);
        check("to_strobes", REGLEN'(n_stb - bs), REGLEN'(1));
`ifdef DBGUART_RX_TIMEOUT_EN
        check("to_pulses", REGLEN'(n_tmo - bt), REGLEN'(1));
        check("to_word",   dbg, 72'h292827262524232221);
`else
        check("to_pulses", REGLEN'(n_tmo - bt), '0);
        check("to_word",   dbg, 72'h262524232221030201);
`endif

        send_byte(8'h61, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        tick_n(CPB / 2);
        do_reset("midrst", 1);
        mark();
        idle_bits(3);
        send_word(8'h71);
        idle_bits(2);
        check("rst_strobes", REGLEN'(n_stb - bs), REGLEN'(1));
        check("rst_word",    dbg, 72'h797877767574737271);

        check("events_drained", REGLEN'(evq.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dbguart_rx.md
# dbguart_rx

Debug UART receiver: the host-to-FPGA counterpart of the debug UART transmitter. It oversamples a serial line at the system clock and deserializes 8N1 bytes, LSB first. It assembles REGLEN/8 consecutive bytes into one REGLEN-bit debug command word and presents that word with a one-cycle strobe. It sits between the board's RX pin and the debug command decoder.

## Interface
Parameters:
- CLKFREQ, 75_000_000, system clock frequency in Hz
- BAUDRATE, 115_200, line rate in baud
- REGLEN, 72, command word width in bits; must be a nonzero multiple of 8
- TIMEOUT_BITS, 20, idle bit-times that abort a partial word (used only with the macro)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_rx  in  1  asynchronous serial input; idles high
- o_dbg  out  REGLEN  last completed command word
- o_dbg_stb  out  1  one-cycle pulse: o_dbg is newly valid
- o_frame_err  out  1  one-cycle pulse: bad stop bit
- o_timeout  out  1  one-cycle pulse: partial word discarded by the idle timeout

Reset and clock: reset i_rst, synchronous, active-high; clock i_clk.

## Operation
- Derived values:
  - CLKS_PER_BIT = CLKFREQ/BAUDRATE, integer division.
  - HALF = CLKS_PER_BIT/2.
  - NBYTES = REGLEN/8.
- i_rx passes through a 2-FF synchronizer. Both flops reset to 1. All logic uses the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on `rx_s`==0, go to START and clear the bit timer.
  - START: after HALF clocks, sample the line. If it is 0, go to DATA. If it is 1, treat it as a glitch and return to IDLE; nothing is recorded.
  - DATA: sample every CLKS_PER_BIT clocks, 8 samples, shifted in LSB first. Then go to STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - If the sample is 1: commit the byte and go to IDLE.
    - If the sample is 0: pulse o_frame_err, discard the byte, clear byte_cnt, and go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE.
- Byte assembly:
  - A committed byte is written to word bits [8*byte_cnt+7 : 8*byte_cnt]. The first byte received lands in bits [7:0].
  - byte_cnt counts 0..NBYTES-1.
  - When the byte at index NBYTES-1 is committed: o_dbg is loaded with the full word, o_dbg_stb pulses, and byte_cnt wraps to 0.
- No backpressure: the consumer must accept o_dbg_stb whenever it pulses. o_dbg holds its value until the next strobe.
- Reset mid-operation: on the next edge, the FSM goes to IDLE, byte_cnt clears, the partial word is discarded, and all outputs clear.

## Timing
- Reset values:
  - o_dbg = 0, o_dbg_stb = 0, o_frame_err = 0, o_timeout = 0.
  - FSM = IDLE, byte_cnt = 0, synchronizer flops = 1.
- Input latency: 2 clocks from an i_rx edge to `rx_s`.
- o_dbg_stb and o_frame_err assert on the clock after the stop-bit sample. Each is exactly 1 cycle wide.
- A STOP success returns the FSM to IDLE mid-stop-bit. This allows a back-to-back start edge to be detected with zero idle time.
- Sample point is the bit centre ±1 clock. Tolerated baud mismatch is at least ±2%.
- o_dbg_stb and o_frame_err never assert in the same cycle.

## Configuration
- Macro: DBGUART_RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs while the FSM is in IDLE and byte_cnt≠0. It clears on leaving IDLE.
  - When it reaches TIMEOUT_BITS*CLKS_PER_BIT: byte_cnt clears, o_timeout pulses for 1 cycle, and the counter clears.
  - This resynchronizes word alignment after a host abort.
- Undefined:
  - No idle counter is built.
  - o_timeout is tied to 0.
  - Partial words persist indefinitely.

## Test plan
Bench parameters: CLKFREQ=1_000_000, BAUDRATE=100_000 (10 clk/bit), REGLEN=72, TIMEOUT_BITS=20.
- Send bytes 0x01..0x09 -> exactly one o_dbg_stb; o_dbg = 72'h090807060504030201; o_frame_err never asserts.
- Drive rx low for 3 clocks, then idle -> no strobe and no error. The following 9-byte word is received intact.
- Send 4 good bytes, then 0xA5 with stop bit 0, then bytes 0x11..0x19 -> one o_frame_err pulse; one o_dbg_stb with o_dbg = 72'h191817161514131211.
- Send two words back-to-back with no idle time -> two strobes 900 clocks apart, both words correct.
- Send 3 bytes, idle 25 bit-times, then bytes 0x21..0x29:
  - With DBGUART_RX_TIMEOUT_EN: o_timeout pulses once; one strobe with o_dbg = 72'h292827262524232221.
  - Without the macro: the strobe fires after byte 0x26, and o_dbg[23:0] holds the first 3 bytes.
- Assert i_rst for 1 cycle during data bit 4 of byte 2 -> all outputs are 0 on the next cycle; the next full word is received correctly.
